// File: rtl/pipe_ctrl_unit.sv
// ID-stage control unit: decodes opCode into a registered ID/EX control bundle,
// inserts bubbles on hazard/flush and sequences multi-cycle MUL with a two-state FSM.
module pipe_ctrl_unit #(
    parameter int OP_CODE_LEN = 4,
    parameter int EXE_CMD_LEN = 4,
    parameter int MUL_CYCLES  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OP_CODE_LEN-1:0] opCode,
    input  logic                   hazard_detected,
    input  logic                   flush,
    output logic                   stall,
    output logic                   busy,
    output logic [EXE_CMD_LEN-1:0] EXE_CMD,
    output logic [1:0]             Branch_command,
    output logic                   branchEn,
    output logic                   Is_Imm,
    output logic                   ST_or_BNE,
    output logic                   WB_EN,
    output logic                   MEM_R_EN,
    output logic                   MEM_W_EN,
    output logic                   illegal_op,
    output logic                   state_dbg
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    localparam logic [OP_CODE_LEN-1:0] OP_NOP  = OP_CODE_LEN'(0);
    localparam logic [OP_CODE_LEN-1:0] OP_ADD  = OP_CODE_LEN'(1);
    localparam logic [OP_CODE_LEN-1:0] OP_SUB  = OP_CODE_LEN'(2);
    localparam logic [OP_CODE_LEN-1:0] OP_AND  = OP_CODE_LEN'(3);
    localparam logic [OP_CODE_LEN-1:0] OP_OR   = OP_CODE_LEN'(4);
    localparam logic [OP_CODE_LEN-1:0] OP_ADDI = OP_CODE_LEN'(5);
    localparam logic [OP_CODE_LEN-1:0] OP_MUL  = OP_CODE_LEN'(6);
    localparam logic [OP_CODE_LEN-1:0] OP_LDR  = OP_CODE_LEN'(7);
    localparam logic [OP_CODE_LEN-1:0] OP_STR  = OP_CODE_LEN'(8);
    localparam logic [OP_CODE_LEN-1:0] OP_BEQ  = OP_CODE_LEN'(9);
    localparam logic [OP_CODE_LEN-1:0] OP_BNE  = OP_CODE_LEN'(10);
    localparam logic [OP_CODE_LEN-1:0] OP_JMP  = OP_CODE_LEN'(11);

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [EXE_CMD_LEN-1:0] exe_cmd;
        logic [1:0]             br_cmd;
        logic                   branch_en;
        logic                   is_imm;
        logic                   st_or_bne;
        logic                   wb_en;
        logic                   mem_r_en;
        logic                   mem_w_en;
        logic                   illegal;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    state_t        state;
    logic [CW-1:0] count;
    ctrl_t         ctrl_q;
    ctrl_t         dec;

    function automatic ctrl_t mul_ctrl(input logic wb);
        ctrl_t c;
        c         = BUBBLE;
        c.exe_cmd = EXE_CMD_LEN'(5);
        c.wb_en   = wb;
        return c;
    endfunction

    always_comb begin
        dec = BUBBLE;
        case (opCode)
            OP_NOP:  dec = BUBBLE;
            OP_ADD:  begin dec.exe_cmd = EXE_CMD_LEN'(1); dec.wb_en = 1'b1; end
            OP_SUB:  begin dec.exe_cmd = EXE_CMD_LEN'(2); dec.wb_en = 1'b1; end
            OP_AND:  begin dec.exe_cmd = EXE_CMD_LEN'(3); dec.wb_en = 1'b1; end
            OP_OR:   begin dec.exe_cmd = EXE_CMD_LEN'(4); dec.wb_en = 1'b1; end
            OP_ADDI: begin
                dec.exe_cmd = EXE_CMD_LEN'(1);
                dec.is_imm  = 1'b1;
                dec.wb_en   = 1'b1;
            end
            OP_MUL:  dec = mul_ctrl(1'b0);
            OP_LDR:  begin
                dec.exe_cmd  = EXE_CMD_LEN'(1);
                dec.is_imm   = 1'b1;
                dec.wb_en    = 1'b1;
                dec.mem_r_en = 1'b1;
            end
            OP_STR:  begin
                dec.exe_cmd   = EXE_CMD_LEN'(1);
                dec.is_imm    = 1'b1;
                dec.st_or_bne = 1'b1;
                dec.mem_w_en  = 1'b1;
            end
            OP_BEQ:  begin
                dec.exe_cmd   = EXE_CMD_LEN'(2);
                dec.br_cmd    = 2'b01;
                dec.branch_en = 1'b1;
            end
            OP_BNE:  begin
                dec.exe_cmd   = EXE_CMD_LEN'(2);
                dec.br_cmd    = 2'b10;
                dec.branch_en = 1'b1;
                dec.st_or_bne = 1'b1;
            end
            OP_JMP:  begin
                dec.br_cmd    = 2'b11;
                dec.branch_en = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Front-end handshake: stall=1 means the opCode in IF/ID is not consumed this
    // cycle and PC/IF/ID must hold it; stall=0 means it is taken at the next edge.
    // Flush always releases the front end so the branch target can enter.
    always_comb begin
        stall = 1'b0;
        if (rst_n && !flush) begin
            if (state == MUL_BUSY)
                stall = 1'b1;
            else if (hazard_detected)
                stall = 1'b1;
            else if (opCode == OP_MUL && MUL_CYCLES > 1)
                stall = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            ctrl_q <= BUBBLE;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush || hazard_detected) begin
                        ctrl_q <= BUBBLE;
                    end else if (opCode == OP_MUL) begin
                        if (MUL_CYCLES == 1) begin
                            ctrl_q <= mul_ctrl(1'b1);
                        end else begin
                            ctrl_q <= mul_ctrl(1'b0);
                            count  <= CW'(MUL_CYCLES - 1);
                            state  <= MUL_BUSY;
                            busy   <= 1'b1;
                        end
                    end else begin
                        ctrl_q <= dec;
                    end
                end
                MUL_BUSY: begin
                    if (flush) begin
                        // Abort: the MUL never reaches its write-back cycle.
                        ctrl_q <= BUBBLE;
                        count  <= '0;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        ctrl_q <= mul_ctrl(count == CW'(1));
                        count  <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    count  <= '0;
                    ctrl_q <= BUBBLE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign EXE_CMD        = ctrl_q.exe_cmd;
    assign Branch_command = ctrl_q.br_cmd;
    assign branchEn       = ctrl_q.branch_en;
    assign Is_Imm         = ctrl_q.is_imm;
    assign ST_or_BNE      = ctrl_q.st_or_bne;
    assign WB_EN          = ctrl_q.wb_en;
    assign MEM_R_EN       = ctrl_q.mem_r_en;
    assign MEM_W_EN       = ctrl_q.mem_w_en;
    assign illegal_op     = ctrl_q.illegal;
    assign state_dbg      = (state == MUL_BUSY);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed and random checks of pipe_ctrl_unit with an expected-output queue;
// vectors are {busy, EXE_CMD, Branch_command, branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, illegal_op}.
module tb_pipe_ctrl_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] opCode;
    logic       hazard_detected;
    logic       flush;
    logic       stall;
    logic       busy;
    logic [3:0] EXE_CMD;
    logic [1:0] Branch_command;
    logic       branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN, illegal_op;
    logic       state_dbg;

    pipe_ctrl_unit #(
        .OP_CODE_LEN(4),
        .EXE_CMD_LEN(4),
        .MUL_CYCLES (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opCode         (opCode),
        .hazard_detected(hazard_detected),
        .flush          (flush),
        .stall          (stall),
        .busy           (busy),
        .EXE_CMD        (EXE_CMD),
        .Branch_command (Branch_command),
        .branchEn       (branchEn),
        .Is_Imm         (Is_Imm),
        .ST_or_BNE      (ST_or_BNE),
        .WB_EN          (WB_EN),
        .MEM_R_EN       (MEM_R_EN),
        .MEM_W_EN       (MEM_W_EN),
        .illegal_op     (illegal_op),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [13:0] exp_q[$];
    logic [12:0] ref_tbl [16];

    // flags order: branchEn Is_Imm ST_or_BNE WB_EN MEM_R_EN MEM_W_EN illegal_op
    function automatic logic [13:0] v(input logic b, input logic [3:0] exe,
                                      input logic [1:0] br, input logic [6:0] fl);
        return {b, exe, br, fl};
    endfunction

    function automatic logic [13:0] observed();
        return {busy, EXE_CMD, Branch_command, branchEn, Is_Imm, ST_or_BNE,
                WB_EN, MEM_R_EN, MEM_W_EN, illegal_op};
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag);
        logic [13:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, observed());
        end else begin
            e = exp_q.pop_front();
            check(tag, observed(), e);
        end
    endtask

    // driver: present inputs, check combinational stall, then the registered bundle
    task automatic step(input string tag, input logic [3:0] op, input logic haz,
                        input logic fl, input logic exp_stall, input logic [13:0] exp_out);
        opCode          = op;
        hazard_detected = haz;
        flush           = fl;
        #1;
        check({tag, "_stall"}, {13'd0, stall}, {13'd0, exp_stall});
        exp_q.push_back(exp_out);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    localparam logic [13:0] BUB = 14'd0;

    logic [13:0] e_add, e_sub, e_str, e_bne, e_ill, e_mul0, e_mul1, e_mulw;

    initial begin
        ref_tbl = '{
            {4'd0, 2'b00, 7'b0000000}, {4'd1, 2'b00, 7'b0001000},
            {4'd2, 2'b00, 7'b0001000}, {4'd3, 2'b00, 7'b0001000},
            {4'd4, 2'b00, 7'b0001000}, {4'd1, 2'b00, 7'b0101000},
            {4'd5, 2'b00, 7'b0000000}, {4'd1, 2'b00, 7'b0101100},
            {4'd1, 2'b00, 7'b0110010}, {4'd2, 2'b01, 7'b1000000},
            {4'd2, 2'b10, 7'b1010000}, {4'd0, 2'b11, 7'b1000000},
            {4'd0, 2'b00, 7'b0000001}, {4'd0, 2'b00, 7'b0000001},
            {4'd0, 2'b00, 7'b0000001}, {4'd0, 2'b00, 7'b0000001}
        };
        e_add  = v(1'b0, 4'd1, 2'b00, 7'b0001000);
        e_sub  = v(1'b0, 4'd2, 2'b00, 7'b0001000);
        e_str  = v(1'b0, 4'd1, 2'b00, 7'b0110010);
        e_bne  = v(1'b0, 4'd2, 2'b10, 7'b1010000);
        e_ill  = v(1'b0, 4'd0, 2'b00, 7'b0000001);
        e_mul0 = v(1'b1, 4'd5, 2'b00, 7'b0000000);
        e_mul1 = v(1'b1, 4'd5, 2'b00, 7'b0000000);
        e_mulw = v(1'b0, 4'd5, 2'b00, 7'b0001000);

        // reset with a MUL presented: outputs bubble, stall held low
        rst_n           = 1'b0;
        opCode          = 4'd6;
        hazard_detected = 1'b0;
        flush           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", observed(), BUB);
        check("reset_stall", {13'd0, stall}, 14'd0);
        check("reset_state", {13'd0, state_dbg}, 14'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ADD
        step("add", 4'd1, 1'b0, 1'b0, 1'b0, e_add);

        // 2: STR behind a two-cycle hazard
        step("str_haz1", 4'd8, 1'b1, 1'b0, 1'b1, BUB);
        step("str_haz2", 4'd8, 1'b1, 1'b0, 1'b1, BUB);
        step("str",      4'd8, 1'b0, 1'b0, 1'b0, e_str);

        // 3: MUL, 3 cycles; hazard during MUL_BUSY must be ignored
        step("mul_c1", 4'd6, 1'b0, 1'b0, 1'b1, e_mul0);
        check("mul_state_busy", {13'd0, state_dbg}, 14'd1);
        step("mul_c2", 4'd1, 1'b1, 1'b0, 1'b1, e_mul1);
        step("mul_c3", 4'd1, 1'b0, 1'b0, 1'b1, e_mulw);
        check("mul_state_idle", {13'd0, state_dbg}, 14'd0);
        step("after_mul", 4'd1, 1'b0, 1'b0, 1'b0, e_add);

        // 4: MUL aborted by flush in the 2nd busy cycle
        step("mulf_c1", 4'd6, 1'b0, 1'b0, 1'b1, e_mul0);
        step("mulf_c2", 4'd2, 1'b0, 1'b0, 1'b1, e_mul1);
        step("mulf_flush", 4'd2, 1'b0, 1'b1, 1'b0, BUB);
        check("mulf_state", {13'd0, state_dbg}, 14'd0);
        step("mulf_next", 4'd2, 1'b0, 1'b0, 1'b0, e_sub);

        // flush and hazard together in IDLE: flush wins
        step("flush_haz", 4'd1, 1'b1, 1'b1, 1'b0, BUB);

        // 5: BNE, illegal opcodes
        step("bne",   4'd10, 1'b0, 1'b0, 1'b0, e_bne);
        step("ill13", 4'd13, 1'b0, 1'b0, 1'b0, e_ill);
        step("ill15", 4'd15, 1'b0, 1'b0, 1'b0, e_ill);
        step("nop",   4'd0,  1'b0, 1'b0, 1'b0, BUB);

        // random non-MUL opcodes with random hazards
        for (int i = 0; i < 24; i++) begin
            logic [3:0] op;
            logic       haz;
            op  = 4'($urandom_range(0, 15));
            if (op == 4'd6) op = 4'd0;
            haz = 1'($urandom_range(0, 1));
            step("rand", op, haz, 1'b0, haz, haz ? BUB : {1'b0, ref_tbl[op]});
        end

        // 6: asynchronous reset mid-MUL
        step("mulr_c1", 4'd6, 1'b0, 1'b0, 1'b1, e_mul0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", observed(), BUB);
        check("async_rst_stall", {13'd0, stall}, 14'd0);
        check("async_rst_state", {13'd0, state_dbg}, 14'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_add", 4'd1, 1'b0, 1'b0, 1'b0, e_add);

        check("queue_empty", 14'(exp_q.size()), 14'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
